// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, prefetches ROM words into a small FIFO and
// hands them to the sequencer over valid/ready. Optional FETCH_IMM_PAIR_EN pairs operand words.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr
`ifdef FETCH_IMM_PAIR_EN
    ,
    output logic [15:0] imm
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2) begin : g_depth_check
        $error("fetch_queue: DEPTH must be at least 2");
    end

    logic [15:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      word_q [DEPTH];
    logic [15:0]      addr_q [DEPTH];

    logic             pop_c;
    logic             push_c;
    logic             wr_en_c;
    logic [CNT_W-1:0] pop_amt_c;
    logic [PTR_W-1:0] pop_step_c;
    logic [15:0]      head_word_c;
    logic             pair_c;

    assign head_word_c = word_q[rd_ptr_q];

`ifdef FETCH_IMM_PAIR_EN
    // Immediate-source and branch/jump heads travel with the following word as their operand.
    assign pair_c = (head_word_c[9:0] == 10'h3A0) || (head_word_c[15:11] == 5'b11100);
    assign imm    = word_q[rd_ptr_q + PTR_W'(1)];
`else
    assign pair_c = 1'b0;
`endif

    assign rom_addr    = pc_q;
    assign instr       = head_word_c;
    assign instr_pc    = addr_q[rd_ptr_q];
    assign instr_valid = (count_q != '0) && (!pair_c || (count_q >= CNT_W'(2)));

    assign pop_c      = instr_valid && instr_ready;
    assign push_c     = (count_q < CNT_W'(DEPTH)) || pop_c;
    assign wr_en_c    = push_c && !redirect;
    assign pop_step_c = pair_c ? PTR_W'(2) : PTR_W'(1);
    assign pop_amt_c  = pop_c ? (pair_c ? CNT_W'(2) : CNT_W'(1)) : '0;

    // Next-state: redirect overrides any push/pop bookkeeping.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d     = redirect_addr;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                pc_d     = pc_q + 16'd1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + pop_step_c;
            end
            count_d = count_q + CNT_W'(push_c) - pop_amt_c;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head outputs read zero out of reset.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            word_q[wr_ptr_q] <= rom_data;
            addr_q[wr_ptr_q] <= pc_q;
        end
    end

endmodule
